// File: rtl/adc_capture_if.sv
// adc_capture_if
// ----------------------------------------------------------------------------
// Signal bundle between adc_capture_ctrl and its environment: the AD9280
// sample path, the UART byte sender and the arm/busy/done control lines.
//
//   arm            slave -> master   one-cycle request to start a capture
//   adc_data[7:0]  slave -> master   ADC sample, valid while adc_sample_en is high
//   adc_sample_en  master -> slave   one-cycle sample strobe every DIV clocks
//   tx_data[7:0]   master -> slave   frame byte to the UART sender
//   tx_valid       master -> slave   tx_data valid
//   tx_ready       slave -> master   UART sender accepts the byte
//   busy           master -> slave   controller is not idle
//   done           master -> slave   one-cycle pulse after the last frame byte
//
// master: the capture controller.  slave: ADC driver / UART sender side.
// ----------------------------------------------------------------------------
interface adc_capture_if;
    logic       arm;
    logic [7:0] adc_data;
    logic       adc_sample_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    modport master (
        input  arm, adc_data, tx_ready,
        output adc_sample_en, tx_data, tx_valid, busy, done
    );

    modport slave (
        output arm, adc_data, tx_ready,
        input  adc_sample_en, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// ----------------------------------------------------------------------------
// Triggered-capture scheduler between the AD9280 sampling path and the UART
// byte sender. A free-running divider produces the ADC sample strobe. On arm
// the controller waits for a rising crossing of TRIG_LEVEL (or an auto-trigger
// after AUTO_TRIG strobes), stores DEPTH consecutive samples in an internal
// block RAM and then streams one frame over a valid/ready byte interface:
//   0xA5, DEPTH[15:8], DEPTH[7:0], sample[0..DEPTH-1] [, checksum]
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   adc_capture_if.master (arm, adc_data, adc_sample_en, tx_data,
//         tx_valid, tx_ready, busy, done)
//
// Build option:
//   CAPTURE_CHECKSUM_EN  when defined, a trailing byte holding the mod-256 sum
//                        of the captured samples is appended (frame DEPTH+4);
//                        otherwise the frame ends after the last sample
//                        (frame DEPTH+3).
// ----------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int CLK_FRE    = 50,    // system clock, MHz
    parameter int ADC_FRE    = 500,   // sample rate, kHz
    parameter int DEPTH      = 256,   // samples per capture, 2..65535
    parameter int TRIG_LEVEL = 128,   // 8-bit trigger threshold
    parameter int AUTO_TRIG  = 4096   // strobes before a forced trigger, 0 = never
) (
    input  logic          clk,
    input  logic          rst,
    adc_capture_if.master bus
);

    localparam int DIV = CLK_FRE * 1000 / ADC_FRE;
    localparam int DW  = $clog2(DIV);
    localparam int IW  = $clog2(DEPTH);
    localparam int TW  = (AUTO_TRIG > 1) ? $clog2(AUTO_TRIG) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'((AUTO_TRIG > 0) ? AUTO_TRIG - 1 : 0);
    localparam bit            AUTO_EN   = (AUTO_TRIG != 0);
    localparam logic [7:0]    TRIG_LVL  = 8'(TRIG_LEVEL);
    localparam logic [15:0]   DEPTH_W   = 16'(DEPTH);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_SEND_HDR,
        S_SEND_LEN_H,
        S_SEND_LEN_L,
        S_SEND_DATA
`ifdef CAPTURE_CHECKSUM_EN
        , S_SEND_SUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    prev_q, prev_d;      // previous sample while waiting for trigger
    logic [TW-1:0] tmo_q, tmo_d;        // strobes seen without a trigger
    logic [IW-1:0] idx_q, idx_d;        // buffer write index, then read index
    logic [7:0]    tx_byte_q, tx_byte_d; // header/checksum byte on the bus
    logic          tx_valid_q, tx_valid_d;
    logic          done_q, done_d;
`ifdef CAPTURE_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic          strobe;
    logic          edge_hit;
    logic          xfer;
    logic          ram_we;
    logic          ram_re;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    ram_q;

    assign strobe   = (div_q == DIV_LAST);
    assign edge_hit = (prev_q < TRIG_LVL) && (bus.adc_data >= TRIG_LVL);
    assign xfer     = tx_valid_q && bus.tx_ready;

    // Divider runs in every state so the sample rate never depends on the FSM.
    assign div_d = strobe ? '0 : div_q + 1'b1;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    state_d = S_WAIT_TRIG;
                    prev_d  = 8'hFF;     // guarantees no crossing on the first strobe
                    tmo_d   = '0;
                    idx_d   = '0;
                end
            end

            S_WAIT_TRIG: begin
                if (strobe) begin
                    if (edge_hit || (AUTO_EN && (tmo_q == TMO_LAST))) begin
                        // The triggering sample itself becomes buffer[0].
                        ram_we  = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        state_d = S_CAPTURE;
`ifdef CAPTURE_CHECKSUM_EN
                        sum_d   = bus.adc_data;
`endif
                    end else begin
                        prev_d = bus.adc_data;
                        tmo_d  = tmo_q + 1'b1;
                    end
                end
            end

            S_CAPTURE: begin
                if (strobe) begin
                    ram_we = 1'b1;
`ifdef CAPTURE_CHECKSUM_EN
                    sum_d  = sum_q + bus.adc_data;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        state_d    = S_SEND_HDR;
                        tx_byte_d  = SYNC_BYTE;
                        tx_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_SEND_HDR: begin
                if (xfer) begin
                    tx_byte_d = DEPTH_W[15:8];
                    state_d   = S_SEND_LEN_H;
                end
            end

            S_SEND_LEN_H: begin
                if (xfer) begin
                    tx_byte_d = DEPTH_W[7:0];
                    state_d   = S_SEND_LEN_L;
                end
            end

            S_SEND_LEN_L: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_SEND_DATA;
                end
            end

            // Each data byte costs one bubble cycle (tx_valid low) in which the
            // RAM is read; the registered read data then drives tx_data directly
            // and stays put until the byte is accepted.
            S_SEND_DATA: begin
                if (!tx_valid_q) begin
                    ram_re     = 1'b1;
                    tx_valid_d = 1'b1;
                end else if (bus.tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef CAPTURE_CHECKSUM_EN
                        tx_byte_d  = sum_q;
                        state_d    = S_SEND_SUM;
`else
                        tx_byte_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        tx_valid_d = 1'b0;
                    end
                end
            end

`ifdef CAPTURE_CHECKSUM_EN
            S_SEND_SUM: begin
                if (xfer) begin
                    tx_byte_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif

            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            prev_q     <= 8'hFF;
            tmo_q      <= '0;
            idx_q      <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            prev_q     <= prev_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
`ifdef CAPTURE_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // NOTE: the sample array and its read register have no reset, which keeps
    // them mappable onto a single-port block RAM; nothing reads the RAM output
    // outside SEND_DATA, where it is always freshly loaded first.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx_q] <= bus.adc_data;
        end else if (ram_re) begin
            ram_q <= mem[idx_q];
        end
    end

    assign bus.adc_sample_en = strobe;
    assign bus.tx_data       = (state_q == S_SEND_DATA) ? ram_q : tx_byte_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Triggered-capture scheduler between the AD9280 sampling path and the UART transmitter. Generates the ADC sample strobe, waits for a rising-level trigger (or auto-trigger timeout), and captures a block of DEPTH samples into an internal buffer. It then sequences the block out as a framed byte stream over a valid/ready interface feeding the UART byte sender. It replaces free-running sample-and-send with one coherent, framed snapshot per arm request.

## Interface
- CLK_FRE, 50, system clock in MHz
- ADC_FRE, 500, sample rate in kHz; DIV = CLK_FRE*1000/ADC_FRE (integer, ≥2)
- DEPTH, 256, samples per capture (2..65535)
- TRIG_LEVEL, 128, 8-bit trigger threshold
- AUTO_TRIG, 4096, samples to wait for trigger before forcing one (0 = never force)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle request to start a capture
- adc_data  in  8  sample from AD9280 driver, valid when adc_sample_en is high
- adc_sample_en  out  1  one-cycle sample strobe every DIV clocks
- tx_data  out  8  frame byte to UART sender
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART sender accepts byte
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last frame byte accepted

## Operation
- Divider: free-running counter 0..DIV-1 from reset; adc_sample_en high when counter == DIV-1. Runs in all states.
- States: IDLE, WAIT_TRIG, CAPTURE, SEND_HDR, SEND_LEN_H, SEND_LEN_L, SEND_DATA, SEND_SUM.
- IDLE: arm -> WAIT_TRIG; prev-sample register cleared to 0xFF, timeout counter cleared. arm ignored in all other states.
- WAIT_TRIG, on each strobe: trigger if prev < TRIG_LEVEL and adc_data >= TRIG_LEVEL, or timeout counter reaches AUTO_TRIG-1 (AUTO_TRIG ≠ 0). Triggering sample written to buffer[0]; -> CAPTURE. Otherwise prev <= adc_data, timeout count +1.
- CAPTURE: each strobe writes buffer[wr_idx], wr_idx +1; after buffer[DEPTH-1] written -> SEND_HDR.
- Frame: 0xA5, DEPTH[15:8], DEPTH[7:0], buffer[0..DEPTH-1], then checksum (see Configuration).
- Checksum: 8-bit sum mod 256 of all DEPTH data bytes, accumulated during CAPTURE.
- After final byte accepted: done pulse, -> IDLE.
- Buffer: single-port, synchronous-read RAM of DEPTH×8, inferred as block RAM.

## Timing
- Reset values: adc_sample_en 0, tx_data 0x00, tx_valid 0, busy 0, done 0, state IDLE, divider 0.
- First adc_sample_en DIV cycles after rst deasserts.
- arm sampled at clk edge; busy high the next cycle.
- Handshake: byte transfers on clk edge with tx_valid && tx_ready. While tx_valid && !tx_ready, tx_data and tx_valid hold. tx_valid never deasserts mid-frame except during the 1-cycle RAM read bubble per data byte.
- Data byte latency: next tx_valid ≤2 cycles after previous transfer; tx_ready held high → 1 byte per 2 clocks in SEND_DATA, 1 per clock in header states.
- Strobes during SEND_* are ignored (no capture, no overrun).
- rst mid-frame: immediate return to IDLE, tx_valid drops asynchronously; partial frame is abandoned, buffer contents undefined.
- done is coincident with nothing else; asserted the cycle after the final transfer.

## Configuration
- CAPTURE_CHECKSUM_EN defined: SEND_SUM state present; frame ends with checksum byte; frame length DEPTH+4.
- Not defined: SEND_SUM and sum accumulator removed; SEND_DATA last byte -> done/IDLE; frame length DEPTH+3.

## Test plan
- Reset: assert rst mid-run -> all outputs 0, first adc_sample_en exactly DIV clocks after release (DIV=4: cycle 4).
- Trigger: DEPTH=8, DIV=4, TRIG_LEVEL=128, ramp 100,120,130,140… with arm -> capture starts at 130; frame A5 00 08 82 8C … with correct sum (macro on), done pulse once.
- Auto-trigger: constant 50, AUTO_TRIG=16 -> capture starts at 16th strobe after arm; 8 bytes of 0x32, checksum 0x90.
- Backpressure: tx_ready toggled randomly/held low 20 cycles -> tx_data stable while stalled, no byte lost or duplicated, exact frame match.
- Arm while busy and mid-frame reset: extra arm pulses ignored (one frame only); rst during SEND_DATA -> tx_valid 0, IDLE, next arm produces full fresh frame.
- Macro off: same trigger stimulus -> frame length 11, no checksum byte, done after last data byte.
